// File: rtl/fsm_3cycles_high_pkg.sv
// Shared types and defaults for the consecutive-high run-length detector.
package fsm_3cycles_high_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        DETECT = 2'd2
    } state_t;

    localparam int N_HIGH_DEFAULT = 3;

    // Counter width needed to hold the value n without wrapping.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fsm_3cycles_high.sv
// Raises y once x has been sampled high on N_HIGH consecutive edges; y holds while x stays high.
module fsm_3cycles_high
    import fsm_3cycles_high_pkg::*;
#(
    parameter int N_HIGH = N_HIGH_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic y
);

    localparam int              CW    = cnt_width(N_HIGH);
    localparam logic [CW-1:0]   N_MAX = CW'(N_HIGH);

    if (N_HIGH < 1 || N_HIGH > 255) begin : g_bad_param
        $error("fsm_3cycles_high: N_HIGH must be in 1..255");
    end

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;

    always_comb begin
        cnt_inc = cnt + 1'b1;
    end

    // y is registered alongside the state so it is a pure decode of DETECT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            y     <= 1'b0;
        end else if (!x) begin
            state <= IDLE;
            cnt   <= '0;
            y     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= CW'(1);
                    if (N_HIGH == 1) begin
                        state <= DETECT;
                        y     <= 1'b1;
                    end else begin
                        state <= COUNT;
                        y     <= 1'b0;
                    end
                end
                COUNT: begin
                    // Saturate rather than wrap, even though COUNT never reaches N_MAX.
                    cnt <= (cnt == N_MAX) ? cnt : cnt_inc;
                    if (cnt_inc == N_MAX || cnt == N_MAX) begin
                        state <= DETECT;
                        y     <= 1'b1;
                    end else begin
                        state <= COUNT;
                        y     <= 1'b0;
                    end
                end
                DETECT: begin
                    state <= DETECT;
                    y     <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    y     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_3cycles_high.sv
// Directed checks of the run-length detector at N_HIGH = 3 (default), 1 and 5.
module tb_fsm_3cycles_high;

    logic clk;
    logic rst;
    logic x3, x1, x5;
    logic y3, y1, y5;

    int total = 0;
    int bad   = 0;

    fsm_3cycles_high u_dut3 (.clk(clk), .rst(rst), .x(x3), .y(y3));
    fsm_3cycles_high #(.N_HIGH(1)) u_dut1 (.clk(clk), .rst(rst), .x(x1), .y(y1));
    fsm_3cycles_high #(.N_HIGH(5)) u_dut5 (.clk(clk), .rst(rst), .x(x5), .y(y5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Advance one edge and land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        x3  = 1'b1;
        x1  = 1'b1;
        x5  = 1'b1;
        #1;
        chk("rst_t0_y3", y3, 1'b0);
        chk("rst_t0_y1", y1, 1'b0);

        // 1: held in reset with x high
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_hold_y3", y3, 1'b0);
            chk("rst_hold_y1", y1, 1'b0);
            chk("rst_hold_y5", y5, 1'b0);
        end
        rst = 1'b1;
        step();
        chk("rel_e1_y3", y3, 1'b0);
        chk("rel_e1_n1", y1, 1'b1);
        step();
        chk("rel_e2_y3", y3, 1'b0);
        step();
        chk("rel_e3_y3", y3, 1'b1);
        step();
        chk("rel_e4_n5", y5, 1'b0);
        step();
        chk("rel_e5_n5", y5, 1'b1);

        // 4: deassert
        x3 = 1'b0; x1 = 1'b0; x5 = 1'b0;
        step();
        chk("deassert_y3", y3, 1'b0);
        chk("deassert_y1", y1, 1'b0);
        chk("deassert_y5", y5, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("low_hold_y3", y3, 1'b0);
        end

        // 2: basic detect over 6 edges
        x3 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("basic_e%0d", i + 1), y3, logic'(i >= 2));
        end
        x3 = 1'b0;
        step();
        chk("basic_fall", y3, 1'b0);

        // 3: broken run 1,1,0,1,1,1
        begin
            logic [5:0] pat;
            logic [5:0] exp;
            pat = 6'b111011;
            exp = 6'b100000;
            for (int i = 0; i < 6; i++) begin
                x3 = pat[i];
                step();
                chk($sformatf("broken_e%0d", i + 1), y3, exp[i]);
            end
        end

        // 5: async reset mid-detect, between edges
        chk("pre_async_y3", y3, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_y3", y3, 1'b0);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post_rst_e%0d", i + 1), y3, logic'(i == 2));
        end

        // minimum pulse: exactly 3 high samples
        x3 = 1'b0;
        step();
        chk("minp_low", y3, 1'b0);
        x3 = 1'b1;
        step(); step();
        chk("minp_e2", y3, 1'b0);
        step();
        chk("minp_e3", y3, 1'b1);
        x3 = 1'b0;
        step();
        chk("minp_fall", y3, 1'b0);

        // glitch low between edges must not break the run
        x3 = 1'b1;
        step();
        #2 x3 = 1'b0;
        #2 x3 = 1'b1;
        step();
        chk("glitch_e2", y3, 1'b0);
        step();
        chk("glitch_e3", y3, 1'b1);

        // 6: N_HIGH = 1 single-sample runs
        x1 = 1'b1;
        step();
        chk("n1_e1", y1, 1'b1);
        x1 = 1'b0;
        step();
        chk("n1_low", y1, 1'b0);
        x1 = 1'b1;
        step();
        chk("n1_again", y1, 1'b1);

        // 6: N_HIGH = 5 held for 300 edges, no wrap or drop
        for (int i = 0; i < 300; i++) begin
            x5 = 1'b1;
            step();
            chk($sformatf("n5_e%0d", i + 1), y5, logic'(i >= 4));
        end
        x5 = 1'b0;
        step();
        chk("n5_fall", y5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fsm_3cycles_high.md
# fsm_3cycles_high

Synchronous run-length detector. It asserts output `y` once input `x` has been sampled high on `N_HIGH` consecutive rising clock edges (default 3). `y` stays high for as long as `x` stays high. It sits as a small control primitive behind a synchronised single-bit status input, for example a debounced request or a level qualifier feeding downstream enable logic.

## Interface
- `N_HIGH`, default 3: number of consecutive high samples of `x` required before `y` asserts. Legal range 1..255.
- `clk`, input, 1: rising-edge clock. The single clock domain.
- `rst`, input, 1: asynchronous active-low reset (assert = 0). Deassertion is expected synchronous to `clk`, handled upstream.
- `x`, input, 1: monitored level. Must already be synchronous to `clk`.
- `y`, output, 1: detect flag. Registered, Moore output.

## Operation
- States:
  - IDLE: `x` was low at the last sample, or reset.
  - COUNT: `x` high, run shorter than `N_HIGH`.
  - DETECT: run length ≥ `N_HIGH`.
- Run counter `cnt`:
  - Width is the smallest width holding `N_HIGH`.
  - Cleared in IDLE.
  - Saturates; it never wraps.
- Transitions, evaluated at each rising `clk` edge:
  - Any state with `x`=0: go to IDLE, `cnt`=0.
  - IDLE with `x`=1: `cnt`=1. Go to DETECT if `N_HIGH`=1, else COUNT.
  - COUNT with `x`=1: `cnt`+1. Go to DETECT when the new `cnt` equals `N_HIGH`, else stay in COUNT.
  - DETECT with `x`=1: stay in DETECT. `cnt` holds.
- Output: `y` = 1 only in DETECT. It is decoded from the state register, with no combinational path from `x` to `y`.
- Overlapping runs: a gap of a single low sample fully restarts the count. No partial credit is kept.
- X/Z on `x` while `rst`=0 is ignored.

## Timing
- Reset:
  - `rst`=0 forces IDLE, `cnt`=0 and `y`=0 immediately, without waiting for a clock.
  - It holds these values for as long as `rst` is low.
  - Reset mid-run discards the run. Counting restarts from the first edge after release.
- Assertion latency:
  - With `x` high before edges E1..E_N, `y` rises just after edge E_N.
  - For the default of 3, `y` is high from just after the 3rd consecutive high-sampled edge.
- Deassertion latency: the first edge that samples `x`=0 drops `y` just after that edge, so `y` falls 1 cycle after `x` falls.
- Glitches of `x` between edges have no effect. Only the value at the rising edge counts.
- Minimum `y` pulse is 1 cycle: `x` high for exactly `N_HIGH` sampled edges, then low.

## Structure
- Shared package `fsm_3cycles_high_pkg` holds:
  - the state enum typedef (IDLE, COUNT, DETECT), 2 bits;
  - the default constant `N_HIGH_DEFAULT` = 3.
- The block is a single module with no sub-modules. It consists of:
  - a state register and next-state logic;
  - the saturating counter;
  - output decode.
- Include a parameter range check: elaboration-time error if `N_HIGH` < 1.

## Test plan
1. Reset behaviour: `rst`=0 at t=0 with `x`=1 for 5 cycles gives `y`=0 throughout. Release reset with `x`=1: `y` rises just after the 3rd edge following release.
2. Basic detect: `x` 0→1 and held for 6 edges gives `y`=0 after edges 1–2, and `y`=1 after edges 3–6.
3. Broken run: `x` pattern 1,1,0,1,1,1 on successive edges gives `y`=0 until after the 6th edge. `y`=1 only after that edge.
4. Deassert: with `y`=1, drive `x`=0. `y`=0 just after the next edge and stays low while `x`=0.
5. Asynchronous reset mid-detect: with `y`=1, pulse `rst` low between edges. `y`=0 immediately without a clock edge. After release with `x` held at 1, `y` re-asserts after 3 edges.
6. Parameter sweep: `N_HIGH`=1 gives `y` high after the first high-sampled edge. `N_HIGH`=5 with `x` held high gives `y` after the 5th edge; hold for 300 edges and confirm no wrap or drop.
